// File: rtl/spart_rx_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spart_rx_if : serial-line and bus-side bundle of the SPART receiver     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface spart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic                 rate_en;
  logic                 rd_data;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 framing_err;
  logic                 overrun;
`ifdef RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    output rxd, rate_en, rd_data,
    input  rx_data, rda, framing_err, overrun
`ifdef RX_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  rxd, rate_en, rd_data,
    output rx_data, rda, framing_err, overrun
`ifdef RX_PARITY_EN
    , output parity_err
`endif
  );
endinterface : spart_rx_if
`default_nettype wire

// File: rtl/spart_rx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spart_rx : 8N1 receiver, 16x oversampled, one-byte holding register.    |
// | Define RX_PARITY_EN for 8E1 framing with parity_err.   Rev 1.0          |
// +-------------------------------------------------------------------------+
module spart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  spart_rx_if.slave bus_if
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef RX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd3,
    ST_BRK    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   commit;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rda_q, rda_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;
`ifdef RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   pe_q, pe_d;
`endif

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus_if.rxd};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef RX_PARITY_EN
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    commit  = 1'b0;
`ifdef RX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          tcnt_d  = '0;
        end
      end
      ST_START: begin
        if (bus_if.rate_en) begin
          if (tcnt_q == TICK_HALF) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rxs ? ST_IDLE : ST_DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (bus_if.rate_en) begin
          if (tcnt_q == TICK_LAST) begin
            tcnt_d  = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == BIT_LAST) begin
              bcnt_d  = '0;
`ifdef RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (bus_if.rate_en) begin
          if (tcnt_q == TICK_LAST) begin
            tcnt_d  = '0;
            par_d   = rxs;
            state_d = ST_STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (bus_if.rate_en) begin
          if (tcnt_q == TICK_LAST) begin
            tcnt_d  = '0;
            commit  = 1'b1;
            state_d = rxs ? ST_IDLE : ST_BRK;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      // A held-low line must go high before another start can be seen.
      ST_BRK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A read in the commit cycle frees the holding register for the new frame.
  always_comb begin
    rx_data_d = rx_data_q;
    rda_d     = rda_q;
    fe_d      = fe_q;
    ov_d      = ov_q;
`ifdef RX_PARITY_EN
    pe_d      = pe_q;
`endif
    if (commit) begin
      if (!rda_q || bus_if.rd_data) begin
        rx_data_d = shift_q;
        rda_d     = 1'b1;
        fe_d      = ~rxs;
        ov_d      = 1'b0;
`ifdef RX_PARITY_EN
        pe_d      = (^shift_q) ^ par_q;
`endif
      end else begin
        ov_d = 1'b1;
      end
    end else if (bus_if.rd_data && rda_q) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      ov_d  = 1'b0;
`ifdef RX_PARITY_EN
      pe_d  = 1'b0;
`endif
    end
  end

  assign bus_if.rx_data     = rx_data_q;
  assign bus_if.rda         = rda_q;
  assign bus_if.framing_err = fe_q;
  assign bus_if.overrun     = ov_q;
`ifdef RX_PARITY_EN
  assign bus_if.parity_err  = pe_q;
`endif

endmodule : spart_rx
`default_nettype wire

// File: tb/tb_spart_rx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_spart_rx : scoreboard bench for spart_rx.   Rev 1.0                   |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_spart_rx;
`ifdef RX_PARITY_EN
  localparam int NBITS = 11;
  logic par_bad = 1'b0;
`else
  localparam int NBITS = 10;
`endif
  // Posedges from start-bit drive to the stop-sample (commit) edge at rate_en=1.
  localparam int COMMIT_CYC = 3 + 8 + 16 * (NBITS - 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spart_rx_if u_if ();
  spart_rx u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (u_if)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       ov;
    logic       pe;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int rate_div = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int re_cnt;
    re_cnt = 0;
    u_if.rate_en = 1'b1;
    forever begin
      @(negedge clk);
      if (rate_div <= 1) begin
        u_if.rate_en = 1'b1;
      end else begin
        re_cnt = (re_cnt + 1) % rate_div;
        u_if.rate_en = (re_cnt == 0);
      end
    end
  end

  task automatic drive_bit(input logic b);
    u_if.rxd = b;
    repeat (16 * rate_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
    drive_bit((^d) ^ par_bad);
`endif
    drive_bit(stop);
  endtask

  task automatic sb_push(input logic [7:0] d, input logic fe, input logic ov, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.ov = ov; e.pe = pe;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    int budget;
    budget = 400 * rate_div;
    while (!u_if.rda && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, ".rda"}, {31'd0, u_if.rda}, 32'd1);
    check({tag, ".sb_nonempty"}, {31'd0, sb_q.size() > 0}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, ".rx_data"}, {24'd0, u_if.rx_data}, {24'd0, e.d});
      check({tag, ".framing_err"}, {31'd0, u_if.framing_err}, {31'd0, e.fe});
      check({tag, ".overrun"}, {31'd0, u_if.overrun}, {31'd0, e.ov});
`ifdef RX_PARITY_EN
      check({tag, ".parity_err"}, {31'd0, u_if.parity_err}, {31'd0, e.pe});
`endif
    end
  endtask

  task automatic rd_pulse(input string tag);
    u_if.rd_data = 1'b1;
    @(negedge clk);
    u_if.rd_data = 1'b0;
    check({tag, ".rda_clr"}, {31'd0, u_if.rda}, 32'd0);
    check({tag, ".fe_clr"}, {31'd0, u_if.framing_err}, 32'd0);
    check({tag, ".ov_clr"}, {31'd0, u_if.overrun}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] data);
    check({tag, ".rx_data"}, {24'd0, u_if.rx_data}, {24'd0, data});
    check({tag, ".rda"}, {31'd0, u_if.rda}, 32'd0);
    check({tag, ".fe"}, {31'd0, u_if.framing_err}, 32'd0);
    check({tag, ".ov"}, {31'd0, u_if.overrun}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    u_if.rxd     = 1'b1;
    u_if.rd_data = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain frame, then read.
    sb_push(8'h61, 1'b0, 1'b0, 1'b0);
    send_frame(8'h61, 1'b1);
    sb_check("t1");
    rd_pulse("t1");

    // Short low glitch is rejected.
    u_if.rxd = 1'b0;
    repeat (4) @(negedge clk);
    u_if.rxd = 1'b1;
    repeat (200) @(negedge clk);
    check_idle_outputs("t2", 8'h61);

    // Bad stop bit followed by a line break.
    sb_push(8'h8A, 1'b1, 1'b0, 1'b0);
    send_frame(8'h8A, 1'b0);
    repeat (40) @(negedge clk);
    sb_check("t3");
    rd_pulse("t3");
    repeat (200) @(negedge clk);
    check({"t3", ".brk_no_frame"}, {31'd0, u_if.rda}, 32'd0);
    u_if.rxd = 1'b1;
    repeat (20) @(negedge clk);
    sb_push(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1);
    sb_check("t3b");
    rd_pulse("t3b");

    // Overrun: second frame dropped while first is unread.
    sb_push(8'h02, 1'b0, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1);
    sb_check("t4a");
    sb_push(8'h02, 1'b0, 1'b1, 1'b0);
    send_frame(8'h50, 1'b1);
    sb_check("t4b");
    rd_pulse("t4b");

    // Read landing exactly on the commit edge frees the register for the new frame.
    sb_push(8'h02, 1'b0, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1);
    sb_check("t4c");
    sb_push(8'h50, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h50, 1'b1);
      begin
        repeat (COMMIT_CYC - 1) @(negedge clk);
        u_if.rd_data = 1'b1;
        @(negedge clk);
        u_if.rd_data = 1'b0;
      end
    join
    sb_check("t4d");
    rd_pulse("t4d");

    // Reset in the middle of a frame.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (16 * 5 + 8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5.in_reset", 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (40) @(negedge clk);
    check_idle_outputs("t5.after", 8'h00);
    sb_push(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1);
    sb_check("t5");
    rd_pulse("t5");

    // Slower tick: rate_en one clock in four.
    rate_div = 4;
    repeat (20) @(negedge clk);
    sb_push(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1);
    sb_check("t6");
    rd_pulse("t6");
`ifdef RX_PARITY_EN
    par_bad = 1'b1;
    sb_push(8'hA5, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1);
    sb_check("t6p");
    rd_pulse("t6p");
    check({"t6p", ".pe_clr"}, {31'd0, u_if.parity_err}, 32'd0);
    par_bad = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule : tb_spart_rx
`default_nettype wire
